// File: rtl/step_ctrl_pkg.sv
// Shared types and default timing constants for the step controller.
package step_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 10 ms debounce and 10 Hz run rate at a 50 MHz system clock
    localparam int DEF_DEB_CYCLES = 500000;
    localparam int DEF_RUN_DIV    = 5000000;

endpackage

// File: rtl/step_ctrl_if.sv
// Key/halt inputs and step outputs of the step controller, bundled as one port.
interface step_ctrl_if;

    logic [1:0]  nKEY;
    logic        HALT;
    logic [1:0]  KEY_PULSE;
    logic        STEP_EN;
    logic        RUNNING;
    logic [15:0] STEP_CNT;

    modport master (
        output nKEY, HALT,
        input  KEY_PULSE, STEP_EN, RUNNING, STEP_CNT
    );

    modport slave (
        input  nKEY, HALT,
        output KEY_PULSE, STEP_EN, RUNNING, STEP_CNT
    );

endinterface

// File: rtl/step_ctrl_key_debounce.sv
// One push-button: two-flop synchronizer, stability-counting debouncer and
// a registered one-cycle pulse on the debounced press (1 -> 0) edge.
module key_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);

    localparam int           CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          deb;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            deb     <= 1'b1;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            pulse   <= 1'b0;
            if (sync_p1 == deb) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // deb still holds the old level: a 1 here means this is a press
                cnt   <= '0;
                deb   <= sync_p1;
                pulse <= deb;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Single-step / free-run controller: debounced keys drive an IDLE/RUN FSM
// that issues one-cycle STEP_EN pulses and counts them.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RUN_DIV    = DEF_RUN_DIV
) (
    input  logic        CLK,
    input  logic        RST,
    step_ctrl_if.slave  bus
);

    localparam int            PW    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(RUN_DIV - 1);

    logic [1:0]    key_pulse;
    state_t        state;
    logic [PW-1:0] presc;
    logic          step_en;
    logic          running;
    logic [15:0]   step_cnt;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_step (
        .clk   (CLK),
        .rst   (RST),
        .key_n (bus.nKEY[0]),
        .pulse (key_pulse[0])
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_run (
        .clk   (CLK),
        .rst   (RST),
        .key_n (bus.nKEY[1]),
        .pulse (key_pulse[1])
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            presc    <= '0;
            step_en  <= 1'b0;
            running  <= 1'b0;
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + {15'd0, step_en};
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (key_pulse[1] && !bus.HALT) begin
                        state   <= RUN;
                        running <= 1'b1;
                        step_en <= 1'b0;
                    end else begin
                        // run/halt key outranks a coincident single-step press
                        step_en <= key_pulse[0] && !key_pulse[1];
                    end
                end
                RUN: begin
                    if (key_pulse[1] || bus.HALT) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        step_en <= 1'b0;
                        presc   <= '0;
                    end else begin
                        presc   <= (presc == PLAST) ? '0 : presc + PW'(1);
                        step_en <= (presc == PLAST);
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    step_en <= 1'b0;
                    presc   <= '0;
                end
            endcase
        end
    end

    assign bus.KEY_PULSE = key_pulse;
    assign bus.STEP_EN   = step_en;
    assign bus.RUNNING   = running;
    assign bus.STEP_CNT  = step_cnt;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: directed key/halt/reset scenarios with
// hand-computed event cycles, plus a fast-stepping instance for counter wrap.
module tb_step_ctrl;

    typedef struct {
        int          cyc;
        logic [1:0]  kp;
        logic        se;
        logic [15:0] cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    ev_t  q[$];
    ev_t  mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_ctrl_if ifm ();
    step_ctrl_if ifw ();

    step_ctrl #(.DEB_CYCLES(4), .RUN_DIV(3)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (ifm)
    );

    step_ctrl #(.DEB_CYCLES(4), .RUN_DIV(1)) dut_w (
        .CLK (clk),
        .RST (rst),
        .bus (ifw)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] kp, input logic se);
        ev_t e;
        e.cyc = c;
        e.kp  = kp;
        e.se  = se;
        e.cnt = exp_cnt[15:0];
        if (se) exp_cnt++;
        q.push_back(e);
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every output event of the main DUT is matched against the queue
    always @(negedge clk) begin
        if (ifm.KEY_PULSE != 2'b00 || ifm.STEP_EN) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cycle %0d key_pulse=%b step_en=%b, required no event",
                         cyc, ifm.KEY_PULSE, ifm.STEP_EN);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.cyc || ifm.KEY_PULSE != mon_e.kp || ifm.STEP_EN != mon_e.se ||
                    (mon_e.se && ifm.STEP_CNT != mon_e.cnt)) begin
                    errors++;
                    $display("FAIL event: got cycle %0d kp=%b se=%b cnt=%0d, required cycle %0d kp=%b se=%b cnt=%0d",
                             cyc, ifm.KEY_PULSE, ifm.STEP_EN, ifm.STEP_CNT,
                             mon_e.cyc, mon_e.kp, mon_e.se, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        int t;
        int n;
        bit done;
        ifm.nKEY = 2'b11;
        ifm.HALT = 1'b0;
        ifw.nKEY = 2'b11;
        ifw.HALT = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_key_pulse", ifm.KEY_PULSE, 0);
        chk("reset_step_en", ifm.STEP_EN, 0);
        chk("reset_running", ifm.RUNNING, 0);
        chk("reset_step_cnt", ifm.STEP_CNT, 0);
        rst = 1'b0;
        goto(cyc + 3);

        // Clean single-step press
        t = cyc;
        ifm.nKEY[0] = 1'b0;
        push(t + 6, 2'b01, 1'b0);
        push(t + 7, 2'b00, 1'b1);
        goto(t + 10);
        ifm.nKEY[0] = 1'b1;
        goto(t + 20);
        chk("step_cnt_single", ifm.STEP_CNT, 1);

        // Bouncing press: 2-cycle runs, then settles low at t+12
        t = cyc;
        push(t + 18, 2'b01, 1'b0);
        push(t + 19, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            goto(t + 2 * i);
            ifm.nKEY[0] = 1'((i % 2) == 1);
        end
        goto(t + 12);
        ifm.nKEY[0] = 1'b0;
        goto(t + 22);
        ifm.nKEY[0] = 1'b1;
        goto(t + 32);
        chk("step_cnt_bounce", ifm.STEP_CNT, 2);

        // Run mode, key0 ignored while running, exit coinciding with a wrap
        t = cyc;
        ifm.nKEY[1] = 1'b0;
        push(t + 6, 2'b10, 1'b0);
        push(t + 10, 2'b00, 1'b1);
        push(t + 13, 2'b00, 1'b1);
        push(t + 14, 2'b01, 1'b0);
        push(t + 16, 2'b00, 1'b1);
        push(t + 19, 2'b00, 1'b1);
        push(t + 22, 2'b00, 1'b1);
        push(t + 24, 2'b10, 1'b0);
        goto(t + 5);
        ifm.nKEY[1] = 1'b1;
        goto(t + 6);
        chk("run_before_entry", ifm.RUNNING, 0);
        goto(t + 7);
        chk("run_entered", ifm.RUNNING, 1);
        goto(t + 8);
        ifm.nKEY[0] = 1'b0;
        goto(t + 13);
        ifm.nKEY[0] = 1'b1;
        goto(t + 18);
        ifm.nKEY[1] = 1'b0;
        goto(t + 23);
        ifm.nKEY[1] = 1'b1;
        goto(t + 24);
        chk("run_last_cycle", ifm.RUNNING, 1);
        goto(t + 25);
        chk("run_exited", ifm.RUNNING, 0);
        goto(t + 40);
        chk("step_cnt_run", ifm.STEP_CNT, 7);

        // HALT exits RUN on a wrap cycle; key1 under HALT is ignored in IDLE
        t = cyc;
        ifm.nKEY[1] = 1'b0;
        push(t + 6, 2'b10, 1'b0);
        push(t + 10, 2'b00, 1'b1);
        push(t + 13, 2'b00, 1'b1);
        push(t + 26, 2'b10, 1'b0);
        goto(t + 5);
        ifm.nKEY[1] = 1'b1;
        goto(t + 15);
        chk("halt_running_before", ifm.RUNNING, 1);
        ifm.HALT = 1'b1;
        goto(t + 16);
        chk("halt_running_after", ifm.RUNNING, 0);
        goto(t + 20);
        ifm.nKEY[1] = 1'b0;
        goto(t + 25);
        ifm.nKEY[1] = 1'b1;
        goto(t + 27);
        chk("halt_blocks_run", ifm.RUNNING, 0);
        goto(t + 35);
        chk("halt_still_idle", ifm.RUNNING, 0);
        ifm.HALT = 1'b0;
        goto(t + 40);

        // Simultaneous key0+key1: RUN wins, no immediate step
        t = cyc;
        ifm.nKEY = 2'b00;
        push(t + 6, 2'b11, 1'b0);
        push(t + 10, 2'b00, 1'b1);
        goto(t + 5);
        ifm.nKEY = 2'b11;
        goto(t + 7);
        chk("simul_running", ifm.RUNNING, 1);
        chk("simul_no_step", ifm.STEP_EN, 0);
        goto(t + 11);
        ifm.HALT = 1'b1;
        goto(t + 12);
        chk("simul_halted", ifm.RUNNING, 0);
        ifm.HALT = 1'b0;
        goto(t + 25);

        // Reset mid-RUN with key0 mid-debounce
        t = cyc;
        ifm.nKEY[1] = 1'b0;
        push(t + 6, 2'b10, 1'b0);
        push(t + 10, 2'b00, 1'b1);
        goto(t + 5);
        ifm.nKEY[1] = 1'b1;
        goto(t + 8);
        ifm.nKEY[0] = 1'b0;
        goto(t + 11);
        chk("pre_reset_step_cnt", ifm.STEP_CNT, 11);
        chk("pre_reset_running", ifm.RUNNING, 1);
        rst = 1'b1;
        ifm.nKEY[0] = 1'b1;
        goto(t + 12);
        chk("mid_reset_running", ifm.RUNNING, 0);
        chk("mid_reset_step_cnt", ifm.STEP_CNT, 0);
        chk("mid_reset_key_pulse", ifm.KEY_PULSE, 0);
        goto(t + 13);
        rst = 1'b0;
        exp_cnt = 0;
        goto(t + 35);
        chk("post_reset_running", ifm.RUNNING, 0);
        chk("post_reset_step_cnt", ifm.STEP_CNT, 0);

        // Key held through reset release
        t = cyc;
        rst = 1'b1;
        ifm.nKEY[0] = 1'b0;
        goto(t + 2);
        rst = 1'b0;
        push(t + 8, 2'b01, 1'b0);
        push(t + 9, 2'b00, 1'b1);
        goto(t + 12);
        ifm.nKEY[0] = 1'b1;
        goto(t + 25);
        chk("held_reset_step_cnt", ifm.STEP_CNT, 1);

        // Counter wrap on the every-cycle instance
        t = cyc;
        ifw.nKEY[1] = 1'b0;
        goto(t + 5);
        ifw.nKEY[1] = 1'b1;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 70000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (ifw.STEP_EN) begin
                if (n == 65535) chk("wrap_pre", ifw.STEP_CNT, 65535);
                n++;
                if (n == 65536) done = 1'b1;
            end
        end
        chk("wrap_steps", n, 65536);
        @(posedge clk);
        #1;
        chk("wrap_zero", ifw.STEP_CNT, 0);
        ifw.HALT = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("wrap_halted", ifw.RUNNING, 0);
        ifw.HALT = 1'b0;

        goto(cyc + 5);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, is the number of consecutive stable cycles required to accept a key level change (10 ms at 50 MHz).
REQ-002 Parameter RUN_DIV, default 5000000, is the number of CLK cycles between consecutive STEP_EN pulses in run mode (10 Hz at 50 MHz).
REQ-003 Port CLK, input, 1, is the single system clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1, is the reset, synchronous and active-high.
REQ-005 Port nKEY, input, 2, carries the raw asynchronous push-buttons, active-low: [0] is single step and [1] is run/halt toggle.
REQ-006 Port HALT, input, 1, is an external stop request, synchronous to CLK.
REQ-007 Port KEY_PULSE, output, 2, is a one-cycle pulse per debounced key press.
REQ-008 Port STEP_EN, output, 1, is a one-cycle clock enable that advances the processor by one instruction.
REQ-009 Port RUNNING, output, 1, is high while in state RUN.
REQ-010 Port STEP_CNT, output, 16, counts the STEP_EN pulses issued.

Function
REQ-011 Each nKEY bit shall pass through a two-flop synchronizer before any other use.
REQ-012 Debouncing shall be per key:
- The debounced level changes only after DEB_CYCLES consecutive cycles in which the synchronized level differs from the debounced level.
- Any cycle where the levels agree clears that key's counter.
REQ-013 KEY_PULSE[i] shall be high for exactly one cycle on the cycle the debounced level of key i goes 1->0; release generates no pulse.
REQ-014 Latency: a raw press held stable from cycle t shall produce KEY_PULSE at cycle t+2+DEB_CYCLES.
REQ-015 The control FSM shall have two states, IDLE and RUN; RUNNING is high in RUN only.
REQ-016 In IDLE, KEY_PULSE[0] at cycle t shall give STEP_EN=1 at cycle t+1 only.
REQ-017 In IDLE, KEY_PULSE[1] with HALT low shall enter RUN at the next cycle with the prescaler cleared to 0.
REQ-018 In IDLE, KEY_PULSE[1] with HALT high shall be ignored; the FSM stays in IDLE.
REQ-019 In IDLE, when KEY_PULSE[0] and KEY_PULSE[1] occur in the same cycle, [1] has priority: enter RUN and issue no single step.
REQ-020 In RUN, the prescaler shall count 0..RUN_DIV-1 and wrap to 0.
REQ-021 In RUN, STEP_EN shall pulse on the cycle after the prescaler equals RUN_DIV-1, so the first step occurs RUN_DIV cycles after entering RUN.
REQ-022 In RUN, KEY_PULSE[1] or HALT shall return the FSM to IDLE next cycle; no STEP_EN is issued that next cycle, even if a prescaler wrap coincides.
REQ-023 KEY_PULSE[0] shall be ignored while in RUN.
REQ-024 STEP_CNT shall increment by 1 on every cycle STEP_EN is high, wrapping 0xFFFF->0x0000.
REQ-025 All outputs shall be registered; there are no combinational paths from nKEY or HALT to any output.

Reset
REQ-026 While RST is high:
- FSM = IDLE and prescaler = 0.
- STEP_EN, KEY_PULSE, RUNNING = 0 and STEP_CNT = 0.
- Debounce counters = 0; synchronizer and debounced levels = 1 (released).
REQ-027 RST asserted mid-debounce or mid-RUN shall abort the operation; no pulse is emitted for the aborted event.
REQ-028 A key held pressed through reset release shall produce KEY_PULSE DEB_CYCLES+2 cycles after release.

Structure
REQ-029 Package step_ctrl_pkg shall hold the FSM state enumeration and the DEB_CYCLES/RUN_DIV default constants.
REQ-030 Per-key synchronize+debounce+press-detect shall be sub-module key_debounce, instantiated twice.

Verification (benches use DEB_CYCLES=4, RUN_DIV=3)
REQ-031 Clean press: nKEY[0] 1->0 held 10 cycles -> KEY_PULSE[0] one cycle at t+6, STEP_EN at t+7, STEP_CNT=1.
REQ-032 Bounce: nKEY[0] toggles every 2 cycles for 12 cycles, then stays 0 -> exactly one KEY_PULSE[0], 6 cycles after the last toggle.
REQ-033 Run mode: press key1, wait 10 cycles, press key1 again:
- RUNNING high between the two presses.
- STEP_EN every 3 cycles while RUNNING; none after exit.
- STEP_CNT equals the number of pulses.
REQ-034 HALT: HALT=1 while in RUN -> RUNNING=0 next cycle, no STEP_EN; a key1 press with HALT=1 in IDLE -> stays IDLE.
REQ-035 Simultaneous key0+key1 press in IDLE -> enter RUN, no immediate STEP_EN; STEP_CNT preset near 0xFFFF (via 65535 steps) wraps to 0x0000.
REQ-036 RST pulse mid-RUN and mid-debounce -> all outputs 0, FSM IDLE, no stray KEY_PULSE afterwards.
